alu_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared 8-bit ALU. It accepts operation requests (A, B, 3-bit ALU code) from two independent requesters and grants them round-robin. It drives the combinational ALU from registered operands and captures result and flags. It returns the result through a valid/ready response channel tagged with the requester ID. It sits between instruction-issue logic (or any two masters) and the `alu` instance, which it owns exclusively.

---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 85 ++++++++
 tb/tb_alu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_code, req1_code;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_code;
    logic             alu_carry, alu_zero;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry, rsp_zero;
    logic [CNT_W-1:0] ops_done;
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_code, req1_code,
        input  alu_out, alu_carry, alu_zero, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_code,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, ops_done
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_code, req1_code,
        output alu_out, alu_carry, alu_zero, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_code,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, ops_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port sequencer for the shared ALU (IDLE -> EXEC -> RESP).
// ALU_ARB_FLAGS_EN builds the carry/zero response registers; otherwise both flags read 0.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           r_state;
    logic             r_last, r_id, r_valid;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [2:0]       r_code;
    logic [CNT_W-1:0] r_ops;
    logic             w_idle, w_gnt0, w_gnt1;
    // On a tie the requester that did not win last time is granted.
    assign w_idle = (r_state == IDLE) && !reset;
    assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last);
    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_code   = r_code;
    assign bus.rsp_valid  = r_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.ops_done   = r_ops;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_valid  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_code   <= '0;
            r_result <= '0;
            r_ops    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt0 || w_gnt1) begin
                    r_a     <= w_gnt1 ? bus.req1_a : bus.req0_a;
                    r_b     <= w_gnt1 ? bus.req1_b : bus.req0_b;
                    r_code  <= w_gnt1 ? bus.req1_code : bus.req0_code;
                    r_id    <= w_gnt1;
                    r_last  <= w_gnt1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result <= bus.alu_out;
                    r_valid  <= 1'b1;
                    r_state  <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    r_valid <= 1'b0;
                    r_ops   <= r_ops + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef ALU_ARB_FLAGS_EN
    logic r_carry, r_zero;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_carry <= bus.alu_carry;
            r_zero  <= bus.alu_zero;
        end
    end
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_zero  = r_zero;
`else
    logic w_unused;
    assign w_unused      = &{1'b0, bus.alu_carry, bus.alu_zero};
    assign bus.rsp_carry = 1'b0;
    assign bus.rsp_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   m_last = 1'b1;
    int   m_cnt = 0;
    alu_arbiter_if #(.WIDTH(8), .CNT_W(CW)) bus ();
    alu_arbiter #(.WIDTH(8), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Reference ALU: returns {carry, zero, result}.
    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        logic [8:0] r;
        case (c)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {1'b0, a} - {1'b0, b};
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {a, 1'b0};
            default: r = {a[0], 1'b0, a[7:1]};
        endcase
        return {r[8], r[7:0] == 8'h00, r[7:0]};
    endfunction
    always_comb {bus.alu_carry, bus.alu_zero, bus.alu_out} = alu_f(bus.alu_a, bus.alu_b, bus.alu_code);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_op(input bit v0, input bit v1,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] c0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] c1,
                         input int bp);
        bit w;
        logic [9:0] e;
        logic [7:0] ea, eb;
        logic [2:0] ec;
        bus.req0_valid = v0; bus.req1_valid = v1;
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_code = c0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_code = c1;
        bus.rsp_ready = 1'b0;
        #1;
        w = (v0 && v1) ? !m_last : v1;
        chk("grant_ready0", bus.req0_ready, !w);
        chk("grant_ready1", bus.req1_ready, w);
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        ec = w ? c1 : c0;
        e  = alu_f(ea, eb, ec);
        tick();
        m_last = w;
        bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_code = 3'($urandom);
        bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_code = 3'($urandom);
        #1;
        chk("exec_alu_a", bus.alu_a, ea);
        chk("exec_alu_b", bus.alu_b, eb);
        chk("exec_alu_code", bus.alu_code, ec);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_readies", {bus.req0_ready, bus.req1_ready}, 0);
        tick();
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, w);
        chk("rsp_result", bus.rsp_result, e[7:0]);
`ifdef ALU_ARB_FLAGS_EN
        chk("rsp_carry", bus.rsp_carry, e[9]);
        chk("rsp_zero", bus.rsp_zero, e[8]);
`else
        chk("rsp_carry", bus.rsp_carry, 0);
        chk("rsp_zero", bus.rsp_zero, 0);
`endif
        chk("resp_readies", {bus.req0_ready, bus.req1_ready}, 0);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_result", bus.rsp_result, e[7:0]);
            chk("bp_ready1", bus.req1_ready, 0);
            chk("bp_ops_done", bus.ops_done, m_cnt);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
        chk("ops_done", bus.ops_done, m_cnt);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
    endtask
    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
        bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_code = 3'd0;
        bus.req1_a = 8'h33; bus.req1_b = 8'h44; bus.req1_code = 3'd1;
        tick();
        tick();
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_ops_done", bus.ops_done, 0);
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_code}, 0);
        chk("rst_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero}, 0);
        // Reset during EXEC: req1 accepted, then discarded.
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rsp_valid", bus.rsp_valid, 0);
            chk("mid_ops_done", bus.ops_done, 0);
            chk("idle_readies", {bus.req0_ready, bus.req1_ready}, 0);
        end
        m_last = 1'b1;
        m_cnt  = 0;
        do_op(1, 1, 8'h10, 8'h20, 3'd0, 8'h30, 8'h40, 3'd3, 0);
        do_op(1, 0, 8'h03, 8'h01, 3'b110, 8'h00, 8'h00, 3'd0, 0);
        for (int i = 0; i < 4; i++)
            do_op(1, 1, 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 0);
        do_op(1, 1, 8'h5a, 8'h0f, 3'd2, 8'hf0, 8'h0f, 3'd4, 5);
        do_op(0, 1, 8'h00, 8'h00, 3'd0, 8'h05, 8'h05, 3'd1, 0);
        do_op(1, 0, 8'hff, 8'h01, 3'd0, 8'h00, 8'h00, 3'd0, 1);
        for (int i = 0; i < 20; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            do_op(v0, v1, 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                  $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
